// File: rtl/exe_muldiv.sv
// rtl/exe_muldiv.sv - iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO register pair
module exe_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cancel,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             hi_wen,
    input  logic             lo_wen,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // Low half starts as multiplier / dividend; high half grows into product-high / remainder.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    // Multiplicand magnitude for multiply, divisor magnitude for divide.
    logic [WIDTH-1:0]   a_q, a_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               zero_q, zero_d;
    logic [WIDTH-1:0]   src1_q, src1_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               div0_q, div0_d;

    logic               accept;
    logic               signed_op;
    logic               s1_neg, s2_neg;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH-1:0]   mul_add;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    // State register and all datapath registers, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            a_q       <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            zero_q    <= 1'b0;
            src1_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            a_q       <= a_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            zero_q    <= zero_d;
            src1_q    <= src1_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            div0_q    <= div0_d;
        end
    end

    // Sequencing: accept in IDLE/DONE, WIDTH steps in CALC, one FIX cycle, one DONE pulse; cancel wins.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                accept = start & ~cancel;
                if (accept) begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (cancel) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                busy = 1'b1;
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                accept = start & ~cancel;
                if (accept) begin
                    state_d = S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: operand capture, one shift-add or restoring step per CALC cycle, sign fix and HI/LO update.
    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        a_d       = a_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        zero_d    = zero_q;
        src1_d    = src1_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        div0_d    = div0_q;

        signed_op = ~op[0];
        s1_neg    = signed_op & src1[WIDTH-1];
        s2_neg    = signed_op & src2[WIDTH-1];
        mag1      = s1_neg ? -src1 : src1;
        mag2      = s2_neg ? -src2 : src2;

        mul_add = acc_q[0] ? a_q : '0;
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};

        // No borrow (bit WIDTH clear) means the shifted remainder covers the divisor.
        rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
        trial  = rem_sh - {1'b0, a_q};

        prod = neg_q ? -acc_q : acc_q;
        quo  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        if (accept) begin
            cnt_d     = '0;
            is_div_d  = op[1];
            acc_d     = {{WIDTH{1'b0}}, (op[1] ? mag1 : mag2)};
            a_d       = op[1] ? mag2 : mag1;
            neg_d     = s1_neg ^ s2_neg;
            rem_neg_d = s1_neg;
            zero_d    = op[1] & (src2 == '0);
            src1_d    = src1;
        end else if (state_q == S_CALC && !cancel) begin
            cnt_d = cnt_q + CW'(1);
            if (is_div_q) begin
                acc_d = {(trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0]),
                         acc_q[WIDTH-2:0], ~trial[WIDTH]};
            end else begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
        end

        // Results land on the FIX->DONE edge; zero divisor bypasses the sign fix entirely.
        if (state_q == S_FIX && !cancel) begin
            div0_d = zero_q;
            if (!is_div_q) begin
                hi_d = prod[2*WIDTH-1:WIDTH];
                lo_d = prod[WIDTH-1:0];
            end else if (zero_q) begin
                hi_d = src1_q;
                lo_d = '1;
            end else begin
                hi_d = rem;
                lo_d = quo;
            end
        end

        // MTHI/MTLO only land while no operation is in flight.
        if (!busy && hi_wen) begin
            hi_d = wdata;
        end
        if (!busy && lo_wen) begin
            lo_d = wdata;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign div0 = div0_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// tb/tb_exe_muldiv.sv - scoreboard bench for exe_muldiv at WIDTH=32 and WIDTH=8
module tb_exe_muldiv;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div0;
        logic [31:0] cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t q32[$];
    exp_t q8[$];

    logic        start32 = 1'b0, cancel32 = 1'b0, hi_wen32 = 1'b0, lo_wen32 = 1'b0;
    logic [1:0]  op32 = 2'b00;
    logic [31:0] src1_32 = '0, src2_32 = '0, wdata32 = '0;
    logic        busy32, done32, div0_32;
    logic [31:0] hi32, lo32;

    logic        start8 = 1'b0, cancel8 = 1'b0, hi_wen8 = 1'b0, lo_wen8 = 1'b0;
    logic [1:0]  op8 = 2'b00;
    logic [7:0]  src1_8 = '0, src2_8 = '0, wdata8 = '0;
    logic        busy8, done8, div0_8;
    logic [7:0]  hi8, lo8;

    exe_muldiv #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .cancel(cancel32), .op(op32),
        .src1(src1_32), .src2(src2_32), .hi_wen(hi_wen32), .lo_wen(lo_wen32),
        .wdata(wdata32), .busy(busy32), .done(done32), .div0(div0_32),
        .hi(hi32), .lo(lo32)
    );

    exe_muldiv #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .cancel(cancel8), .op(op8),
        .src1(src1_8), .src2(src2_8), .hi_wen(hi_wen8), .lo_wen(lo_wen8),
        .wdata(wdata8), .busy(busy8), .done(done8), .div0(div0_8),
        .hi(hi8), .lo(lo8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue32(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                           input bit push, input logic [31:0] ehi, input logic [31:0] elo,
                           input logic ediv0);
        exp_t e;
        start32 = 1'b1;
        op32    = o;
        src1_32 = a;
        src2_32 = b;
        if (push) begin
            e.hi   = ehi;
            e.lo   = elo;
            e.div0 = ediv0;
            e.cyc  = cyc + 34;
            q32.push_back(e);
        end
        step(1);
        start32 = 1'b0;
    endtask

    task automatic issue8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ehi, input logic [7:0] elo);
        exp_t e;
        start8 = 1'b1;
        op8    = o;
        src1_8 = a;
        src2_8 = b;
        e.hi   = {24'd0, ehi};
        e.lo   = {24'd0, elo};
        e.div0 = 1'b0;
        e.cyc  = cyc + 10;
        q8.push_back(e);
        step(1);
        start8 = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (q32.size() != 0 || q8.size() != 0); i++) begin
            step(1);
        end
        chk("drain_timeout", q32.size() + q8.size(), 0);
    endtask

    // Monitor for the 32-bit unit: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && done32) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done32: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q32.pop_front();
                chk("hi32", hi32, e.hi);
                chk("lo32", lo32, e.lo);
                chk("div0_32", div0_32, e.div0);
                chk("done_cycle32", cyc, e.cyc);
                chk("busy_in_done32", busy32, 0);
            end
        end
    end

    // Monitor for the 8-bit unit.
    always @(negedge clk) begin
        if (!rst && done8) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done8: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("hi8", hi8, e.hi[7:0]);
                chk("lo8", lo8, e.lo[7:0]);
                chk("div0_8", div0_8, e.div0);
                chk("done_cycle8", cyc, e.cyc);
            end
        end
    end

    initial begin
        step(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy32, 0);
        chk("rst_done", done32, 0);
        chk("rst_div0", div0_32, 0);
        chk("rst_hi", hi32, 0);
        chk("rst_lo", lo32, 0);
        step(1);

        // MULTU all-ones squared, with busy traced across the whole operation.
        issue32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            chk($sformatf("busy_c%0d", k), busy32, (k <= 33));
            if (k < 34) @(posedge clk);
        end
        drain();

        // MULT -3*7, then back-to-back MULT issued in its DONE cycle.
        step(1);
        issue32(2'b00, 32'hFFFF_FFFD, 32'd7, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        step(33);
        issue32(2'b00, 32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, 32'h0, 0);
        drain();

        // Divide by zero cases, then ordinary divides clear div0.
        step(1);
        issue32(2'b11, 32'd5, 32'd0, 1, 32'h0000_0005, 32'hFFFF_FFFF, 1);
        drain();
        issue32(2'b10, 32'hFFFF_FFFB, 32'd0, 1, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1);
        drain();
        step(3);
        @(negedge clk);
        chk("div0_held", div0_32, 1);
        step(1);
        issue32(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0, 32'h8000_0000, 0);
        drain();
        issue32(2'b10, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        drain();

        // Preload HI/LO, cancel mid-CALC, with an ignored start and MTHI while busy.
        step(1);
        hi_wen32 = 1'b1;
        wdata32  = 32'h11;
        step(1);
        hi_wen32 = 1'b0;
        lo_wen32 = 1'b1;
        wdata32  = 32'h22;
        step(1);
        lo_wen32 = 1'b0;
        @(negedge clk);
        chk("preload_hi", hi32, 32'h11);
        chk("preload_lo", lo32, 32'h22);
        step(1);
        issue32(2'b01, 32'd3, 32'd4, 0, 32'h0, 32'h0, 0);
        step(4);
        start32  = 1'b1;
        op32     = 2'b01;
        hi_wen32 = 1'b1;
        wdata32  = 32'hDEAD;
        step(1);
        start32  = 1'b0;
        hi_wen32 = 1'b0;
        step(4);
        cancel32 = 1'b1;
        step(1);
        cancel32 = 1'b0;
        @(negedge clk);
        chk("cancel_busy", busy32, 0);
        chk("cancel_hi", hi32, 32'h11);
        chk("cancel_lo", lo32, 32'h22);
        step(45);
        chk("cancel_hi_late", hi32, 32'h11);
        chk("cancel_lo_late", lo32, 32'h22);

        // Restart with MTHI in the accept cycle, then MTLO in the DONE cycle.
        hi_wen32 = 1'b1;
        wdata32  = 32'h55;
        issue32(2'b01, 32'd3, 32'd4, 1, 32'h0, 32'd12, 0);
        hi_wen32 = 1'b0;
        @(negedge clk);
        chk("mthi_at_start", hi32, 32'h55);
        step(33);
        lo_wen32 = 1'b1;
        wdata32  = 32'h77;
        step(1);
        lo_wen32 = 1'b0;
        @(negedge clk);
        chk("mtlo_in_done_lo", lo32, 32'h77);
        chk("mtlo_in_done_hi", hi32, 32'h0);
        drain();

        // Reset in the middle of CALC.
        step(1);
        issue32(2'b01, 32'd9, 32'd9, 0, 32'h0, 32'h0, 0);
        step(10);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy32, 0);
        chk("midrst_done", done32, 0);
        chk("midrst_hi", hi32, 0);
        chk("midrst_lo", lo32, 0);
        step(40);

        // Narrow instance.
        issue8(2'b01, 8'hFF, 8'hFF, 8'hFE, 8'h01);
        drain();
        issue8(2'b11, 8'hC8, 8'h07, 8'h04, 8'h1C);
        drain();
        issue8(2'b10, 8'h9C, 8'h07, 8'hFE, 8'hF2);
        drain();

        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule

// File: doc/exe_muldiv.md
# exe_muldiv

Parametrised iterative multiply/divide unit for the EXE stage of the five-stage pipeline. It computes MULT/MULTU/DIV/DIVU on WIDTH-bit operands, one bit per cycle, and owns the HI/LO register pair, including direct MTHI/MTLO writes. The EXE stage drives `start` with the decoded operation and holds EXE_over low until `done`. `cancel` aborts an in-flight operation on pipeline flush, such as an exception or ERET.

## Interface
- WIDTH, 32, operand width; even, ≥ 4. HI and LO are WIDTH bits each.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  operation request; accepted only in IDLE or DONE.
- cancel  in  1  abort; synchronous, priority over `start`.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src1  in  WIDTH  multiplicand / dividend.
- src2  in  WIDTH  multiplier / divisor.
- hi_wen, lo_wen  in  1  MTHI / MTLO write enables.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  high in CALC and FIX.
- done  out  1  one-cycle pulse in DONE; hi/lo hold the new result.
- div0  out  1  divisor was zero on the last completed divide; held until the next completion.
- hi, lo  out  WIDTH  HI/LO registers.

## Operation
- States: IDLE → CALC → FIX → DONE → IDLE, or DONE → CALC on back-to-back `start`.
- Accept (`start` & ~`cancel` in IDLE/DONE):
  - Latch op and the operand magnitudes. Signed ops take the two's-complement absolute value; unsigned ops take operands as-is.
  - Latch sign flags and clear the counter.
- CALC, WIDTH cycles, counter 0..WIDTH-1:
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring step. Shift the remainder left, trial-subtract the divisor, set the quotient bit if no borrow.
- FIX, one cycle: apply sign correction.
  - Product negated iff sign(src1)≠sign(src2).
  - Quotient negated iff the signs differ.
  - Remainder takes the sign of the dividend.
- DONE entry loads HI/LO:
  - Multiply: hi = product[2W-1:W], lo = product[W-1:0].
  - Divide: lo = quotient, hi = remainder.
- Divide by zero (DIV or DIVU): lo = all-ones, hi = src1 unmodified, no sign fix, div0 = 1. div0 = 0 on every other completion.
- Overflow, DIV most-negative / −1: lo = most-negative, hi = 0. This falls out of the magnitude path; no special case.
- MTHI/MTLO: hi_wen/lo_wen write wdata when busy = 0, and are ignored while busy.
  - Same cycle as an accepted `start`: the write applies, and the operation result overwrites it later.
  - Write in the DONE cycle: the write wins over the held result.
- `start` while busy is ignored, with no queueing.
- `cancel` in CALC/FIX: IDLE next cycle, no `done`, hi/lo/div0 unchanged.
- `cancel` in IDLE/DONE: `start` is not accepted that cycle.
- `rst` in any state: IDLE.
  - busy, done, div0 = 0; hi, lo = 0.
  - Internal accumulator and counter cleared.

## Timing
- `start` sampled in cycle 0; CALC occupies cycles 1..WIDTH; FIX is cycle WIDTH+1.
- `done` = 1 in cycle WIDTH+2 with hi/lo valid (cycle 34 for WIDTH=32). Latency is identical for all four ops and for divide-by-zero.
- busy = 1 in cycles 1..WIDTH+1; 0 in the DONE cycle.
- Back-to-back: `start` in the DONE cycle puts cycle WIDTH+3 in CALC, so throughput is one op per WIDTH+2 cycles.
- hi/lo change only on DONE entry, on MTHI/MTLO writes, or on reset.
- Reset values: busy=0, done=0, div0=0, hi=0, lo=0.

## Test plan
- MULTU 0xFFFFFFFF×0xFFFFFFFF → done in cycle 34 only; hi=0xFFFFFFFE, lo=0x00000001; busy high in cycles 1–33.
- MULT −3×7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then back-to-back MULT 0x80000000×0x80000000 started in the DONE cycle → hi=0x40000000, lo=0, done in cycle 68.
- DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0, div0=0.
- DIVU 5/0 → div0=1, lo=0xFFFFFFFF, hi=0x00000005. DIV −5/0 → lo=0xFFFFFFFF, hi=0xFFFFFFFB.
- Cancel, restart and busy-blocking:
  - Preload hi=0x11, lo=0x22 via MTHI/MTLO, then start MULTU 3×4 and assert `cancel` in cycle 10 → no done, hi/lo stay 0x11/0x22.
  - `start` and `hi_wen` in cycle 5 while busy → both ignored.
  - Restart → lo=12, hi=0.
- rst mid-CALC → next cycle busy=0, done=0, hi=lo=0.
- WIDTH=8 instance: MULTU 0xFF×0xFF → hi=0xFE, lo=0x01, done in cycle 10.
